// File: rtl/rotate_sequencer.sv
// Multi-cycle rotate/shift sequencer: one single-bit step per clock, with stall and back-to-back start.
// Optional macro ROTSEQ_TRISTATE_EN makes z high-impedance whenever ready is low.
module rotate_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNTW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             hold,
    input  logic             dir,
    input  logic             mode,
    input  logic [CNTW-1:0]  amt,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] z,
    output logic             ready,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        ROTATE = 3'b010,
        DONE   = 3'b100
    } state_t;

    localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    state_t           state_r, state_s;
    logic [WIDTH-1:0] data_r, data_s;
    logic [CNTW-1:0]  cnt_r, cnt_s;
    logic             dir_r, dir_s;
    logic             mode_r, mode_s;

    // One-bit step; the vacated end takes the wrapped bit for rotate, zero for shift.
    function automatic logic [WIDTH-1:0] step_one(
        input logic [WIDTH-1:0] v,
        input logic             d,
        input logic             m
    );
        logic [WIDTH-1:0] res;
        if (d) begin
            res = {v[WIDTH-2:0], (m ? 1'b0 : v[WIDTH-1])};
        end else begin
            res = {(m ? 1'b0 : v[0]), v[WIDTH-1:1]};
        end
        return res;
    endfunction

    // Next-state, data and counter selection.
    always_comb begin
        state_s = state_r;
        data_s  = data_r;
        cnt_s   = cnt_r;
        dir_s   = dir_r;
        mode_s  = mode_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    data_s  = x;
                    cnt_s   = amt;
                    dir_s   = dir;
                    mode_s  = mode;
                    state_s = (amt != CNT_ZERO) ? ROTATE : DONE;
                end else begin
                    state_s = state_r;
                end
            end
            ROTATE: begin
                if (!hold) begin
                    data_s  = step_one(data_r, dir_r, mode_r);
                    cnt_s   = cnt_r - CNT_ONE;
                    state_s = (cnt_r == CNT_ONE) ? DONE : ROTATE;
                end else begin
                    state_s = ROTATE;
                end
            end
            default: begin
                state_s = IDLE;
                data_s  = {WIDTH{1'b0}};
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            data_r  <= {WIDTH{1'b0}};
            cnt_r   <= CNT_ZERO;
            dir_r   <= 1'b0;
            mode_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            data_r  <= data_s;
            cnt_r   <= cnt_s;
            dir_r   <= dir_s;
            mode_r  <= mode_s;
        end
    end

    // Status bits come straight from the one-hot state flops, so no input reaches them.
    assign ready = state_r[2];
    assign busy  = state_r[1];

`ifdef ROTSEQ_TRISTATE_EN
    assign z = ready ? data_r : {WIDTH{1'bz}};
`else
    assign z = ready ? data_r : {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_rotate_sequencer.sv
// Self-checking bench for rotate_sequencer (WIDTH=8): vector table plus stall and abort sequences.
module tb_rotate_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       hold;
    logic       dir;
    logic       mode;
    logic [2:0] amt;
    logic [7:0] x;
    logic [7:0] z;
    logic       ready;
    logic       busy;

    int total = 0;
    int bad   = 0;
    logic [7:0] sb_q[$];

    typedef struct {
        logic [7:0] vx;
        logic       vd;
        logic       vm;
        logic [2:0] va;
        logic [7:0] ez;
    } vec_t;

    vec_t vt[10];

    rotate_sequencer #(.WIDTH(8), .CNTW(3)) dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold), .dir(dir),
        .mode(mode), .amt(amt), .x(x), .z(z), .ready(ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Waits for ready, checking busy while running, then latency and the scoreboard result.
    task automatic wait_done(input int start_edges, input int exp_lat);
        int edges;
        logic [7:0] exp_z;
        edges = start_edges;
        while (!ready && edges < 64) begin
            check("busy_while_running", busy, 1'b1);
            tick();
            edges++;
        end
        check("ready_timeout", ready, 1'b1);
        check("latency", edges, exp_lat);
        check("not_both_high", ready & busy, 1'b0);
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 1'b1, 1'b0);
        end else begin
            exp_z = sb_q.pop_front();
            check("result_z", z, exp_z);
        end
    endtask

    task automatic run_vec(input vec_t v);
        x     = v.vx;
        dir   = v.vd;
        mode  = v.vm;
        amt   = v.va;
        start = 1'b1;
        sb_q.push_back(v.ez);
        tick();
        start = 1'b0;
        x     = ~v.vx;
        dir   = ~v.vd;
        mode  = ~v.vm;
        amt   = 3'($urandom_range(0, 7));
        check("ready_at_start_edge", ready, (v.va == 3'd0));
        wait_done(1, int'(v.va) + 1);
        tick();
        check("persist_z", z, v.ez);
        check("persist_ready", ready, 1'b1);
        tick();
        check("persist_z2", z, v.ez);
    endtask

    initial begin
        vt[0] = '{8'hB4, 1'b0, 1'b0, 3'd3, 8'h96};
        vt[1] = '{8'h81, 1'b1, 1'b0, 3'd1, 8'h03};
        vt[2] = '{8'hB4, 1'b0, 1'b1, 3'd3, 8'h16};
        vt[3] = '{8'hA5, 1'b0, 1'b0, 3'd0, 8'hA5};
        vt[4] = '{8'h81, 1'b1, 1'b1, 3'd7, 8'h80};
        vt[5] = '{8'h81, 1'b0, 1'b1, 3'd7, 8'h01};
        vt[6] = '{8'h3C, 1'b1, 1'b0, 3'd4, 8'hC3};
        vt[7] = '{8'h01, 1'b0, 1'b0, 3'd1, 8'h80};
        vt[8] = '{8'hF0, 1'b1, 1'b1, 3'd2, 8'hC0};
        vt[9] = '{8'h5A, 1'b1, 1'b0, 3'd7, 8'h2D};

        // Reset held two edges while start is asserted.
        rst   = 1'b0;
        start = 1'b1;
        hold  = 1'b0;
        dir   = 1'b0;
        mode  = 1'b0;
        amt   = 3'd3;
        x     = 8'hFF;
        tick();
        tick();
        check("rst_ready", ready, 1'b0);
        check("rst_busy", busy, 1'b0);
`ifndef ROTSEQ_TRISTATE_EN
        check("rst_z", z, 8'h00);
`endif

        // First start coincides with the first edge after reset release.
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            run_vec(vt[i]);
        end

        // Stall for two cycles mid-run with a start pulse that must be ignored.
        x     = 8'hB4;
        dir   = 1'b0;
        mode  = 1'b0;
        amt   = 3'd3;
        start = 1'b1;
        sb_q.push_back(8'h96);
        tick();
        start = 1'b0;
        check("stall_busy0", busy, 1'b1);
        tick();
        hold  = 1'b1;
        start = 1'b1;
        x     = 8'hFF;
        amt   = 3'd0;
        tick();
        check("stall_busy1", busy, 1'b1);
        tick();
        check("stall_busy2", busy, 1'b1);
        hold  = 1'b0;
        start = 1'b0;
        wait_done(4, 6);

        // Abort during the second ROTATE cycle, then a fresh zero-amount start.
        x     = 8'hB4;
        amt   = 3'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("abort_busy_pre", busy, 1'b1);
        rst = 1'b0;
        tick();
        check("abort_busy", busy, 1'b0);
        check("abort_ready", ready, 1'b0);
        check("abort_z", z, 8'h00);
        rst = 1'b1;
        tick();
        check("idle_ready", ready, 1'b0);
        check("idle_busy", busy, 1'b0);
        run_vec('{8'h0F, 1'b0, 1'b0, 3'd0, 8'h0F});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rotate_sequencer.md
ROTATE_SEQUENCER -- requirements
Module: rotate_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width in bits, legal range 2..64.
REQ-002 SHALL have parameter CNTW, default $clog2(WIDTH): width of the amount field.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  request: load x and begin an operation.
REQ-006 SHALL have port hold  input  1  stall: freezes an operation in progress.
REQ-007 SHALL have port dir  input  1  0 = right (toward bit 0), 1 = left.
REQ-008 SHALL have port mode  input  1  0 = rotate, 1 = logical shift with zero fill.
REQ-009 SHALL have port amt  input  CNTW  number of single-bit steps, 0..WIDTH-1.
REQ-010 SHALL have port x  input  WIDTH  operand.
REQ-011 SHALL have port z  output  WIDTH  result, valid while ready=1.
REQ-012 SHALL have port ready  output  1  high in DONE.
REQ-013 SHALL have port busy  output  1  high in ROTATE.

Function
REQ-014 SHALL implement a one-hot FSM with states IDLE, ROTATE and DONE, plus a WIDTH-bit data register R and a CNTW-bit down-counter C.
REQ-015 In IDLE or DONE with start=1 at an edge, SHALL perform all of the following on that edge: R<=x, C<=amt, latch dir and mode, next state ROTATE if amt!=0, else DONE.
REQ-016 In IDLE with start=0, SHALL remain in IDLE.
REQ-017 In DONE with start=0, SHALL remain in DONE with R held, so the result persists until the next start.
REQ-018 In ROTATE with hold=0, SHALL on each edge step R by one bit per the latched dir and mode and set C<=C-1.
REQ-019 In ROTATE, when C==1 and hold=0, SHALL perform the final step on that edge and move to DONE.
REQ-020 In ROTATE with hold=1, SHALL hold R, C and the state unchanged.
REQ-021 In ROTATE, SHALL ignore start.
REQ-022 Changes to dir, mode, amt or x after the start edge SHALL NOT affect the operation in progress.
REQ-023 Latency: ready SHALL rise amt+1 edges after the start edge, plus one edge per held cycle; for amt=0 it SHALL rise after exactly 1 edge.
REQ-024 A start in DONE SHALL begin a new operation back-to-back, with ready falling on that same edge (or staying high if amt=0).
REQ-025 Rotate SHALL be circular; shift SHALL insert 0 at the vacated end.
REQ-026 A shift of WIDTH-1 steps SHALL leave only the original MSB (right) or LSB (left) in R.
REQ-027 ready and busy SHALL decode directly from the state registers, with no combinational path from any input.
REQ-028 ready and busy SHALL never both be high.

Reset
REQ-029 When rst=0 at an edge, SHALL force state IDLE, R=0, C=0, ready=0, busy=0, overriding start and hold.
REQ-030 Reset mid-ROTATE SHALL abort the operation with no partial result presented.
REQ-031 The first start SHALL be accepted on the first edge at which rst=1.

Configuration
REQ-032 Macro ROTSEQ_TRISTATE_EN SHALL select the output drive of z.
REQ-033 With ROTSEQ_TRISTATE_EN defined, z SHALL equal R while ready=1 and be high-impedance otherwise, for sharing a bus.
REQ-034 With ROTSEQ_TRISTATE_EN undefined, z SHALL equal R while ready=1 and all-zeros otherwise; no Z is ever driven.

Verification (WIDTH=8)
REQ-035 Reset: rst=0 for 2 edges with start=1 -> state IDLE, ready=0, busy=0, z=Z (tristate build) or 0x00.
REQ-036 Rotate right: x=0xB4, dir=0, mode=0, amt=3, start one cycle -> busy for 3 edges, ready on the 4th edge, z=0x96 held until the next start.
REQ-037 Rotate left and shift: x=0x81, dir=1, mode=0, amt=1 -> z=0x03; then back-to-back start with x=0xB4, dir=0, mode=1, amt=3 -> z=0x16.
REQ-038 Zero amount: x=0xA5, amt=0 -> ready after 1 edge, busy never high, z=0xA5.
REQ-039 Stall and ignore: x=0xB4, ror amt=3 with hold=1 for 2 cycles mid-run and a start pulse while busy -> ready delayed exactly 2 edges, z=0x96, no restart.
REQ-040 Abort: rst=0 asserted during the 2nd ROTATE cycle -> IDLE next edge, R=0; a fresh start with x=0x0F, amt=0 -> z=0x0F.
